// File: rtl/sym_game_pkg.sv
// rtl/sym_game_pkg.sv - shared game state type, symbol-period width and parameter defaults
package sym_game_pkg;

  typedef enum logic [1:0] {
    PLAY,
    WAIT,
    DONE,
    LOST
  } game_state_e;

  localparam int SYM_PERIOD_W = 32;
  localparam int WAIT_CNT_W   = 16;

  localparam int unsigned HITS_PER_LEVEL_DEF = 10;
  localparam int unsigned MAX_MISSES_DEF     = 3;
  localparam int unsigned WAIT_TIMEOUT_DEF   = 8;

endpackage

// File: rtl/sym_tick_gen.sv
// rtl/sym_tick_gen.sv - programmable symbol-period counter producing a registered one-cycle tick
// A limit of 0 or 1 is treated as 1, giving a tick every enabled cycle.
module sym_tick_gen
  import sym_game_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic [SYM_PERIOD_W-1:0] limit_i,
  output logic                    tick_o
);

  logic [SYM_PERIOD_W-1:0] cnt_q;
  logic [SYM_PERIOD_W-1:0] last_d;
  logic                    tick_q;

  assign last_d = (limit_i <= 32'd1) ? '0 : limit_i - 32'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (en_i) begin
      // >= so a limit lowered below the running count still wraps promptly
      if (cnt_q >= last_d) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + 32'd1;
        tick_q <= 1'b0;
      end
    end else begin
      tick_q <= 1'b0;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/level_progress_ctrl.sv
// rtl/level_progress_ctrl.sv - hit/miss counting and level-advance handshake toward the level controller
// Optional LEVEL_PROG_STATS_EN adds totalHits and lastWaitCycles outputs.
module level_progress_ctrl
  import sym_game_pkg::*;
#(
  parameter int unsigned HITS_PER_LEVEL = HITS_PER_LEVEL_DEF,
  parameter int unsigned MAX_MISSES     = MAX_MISSES_DEF,
  parameter int unsigned WAIT_TIMEOUT   = WAIT_TIMEOUT_DEF
) (
  input  logic                    Clk100M,
  input  logic                    Rst,
  input  logic                    hit,
  input  logic                    miss,
  input  logic                    newLevel,
  input  logic                    victory,
  input  logic [SYM_PERIOD_W-1:0] symGenMax,
  output logic                    incLevel,
  output logic                    symTick,
  output logic [7:0]              hitCount,
  output logic [3:0]              missCount,
  output logic                    gameOver,
`ifdef LEVEL_PROG_STATS_EN
  output logic [15:0]             totalHits,
  output logic [3:0]              lastWaitCycles,
`endif
  output logic                    levelErr
);

  game_state_e           state_q;
  logic [7:0]            hit_cnt_q;
  logic [3:0]            miss_cnt_q;
  logic                  inc_q;
  logic                  game_over_q;
  logic                  level_err_q;
  logic [WAIT_CNT_W-1:0] wait_q;

  logic [8:0]            hit_sum_d;
  logic [4:0]            miss_sum_d;
  logic [WAIT_CNT_W-1:0] wait_sum_d;
  logic                  in_play, in_wait;
  logic                  lost_now, hit_full, counts_live, wait_timeout;
  logic                  tick_en, tick_clr;

  assign in_play      = (state_q == PLAY);
  assign in_wait      = (state_q == WAIT);
  assign hit_sum_d    = {1'b0, hit_cnt_q} + 9'd1;
  assign miss_sum_d   = {1'b0, miss_cnt_q} + 5'd1;
  assign wait_sum_d   = wait_q + WAIT_CNT_W'(1);
  assign lost_now     = in_play && miss && (miss_sum_d == 5'(MAX_MISSES));
  assign hit_full     = hit && (hit_sum_d == 9'(HITS_PER_LEVEL));
  // Counters still move on the losing cycle; victory alone freezes them
  assign counts_live  = in_play && (lost_now || !victory);
  assign wait_timeout = (wait_sum_d == WAIT_CNT_W'(WAIT_TIMEOUT));
  assign tick_en      = in_play && !lost_now && !victory && !hit_full;
  assign tick_clr     = in_wait && newLevel && !victory;

  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      state_q     <= PLAY;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      inc_q       <= 1'b0;
      game_over_q <= 1'b0;
      level_err_q <= 1'b0;
      wait_q      <= '0;
    end else begin
      inc_q <= 1'b0;
      case (state_q)
        PLAY: begin
          if (counts_live && hit) hit_cnt_q <= hit_full ? 8'd0 : hit_sum_d[7:0];
          if (counts_live && miss) miss_cnt_q <= miss_sum_d[3:0];
          if (lost_now) begin
            game_over_q <= 1'b1;
            state_q     <= LOST;
          end else if (victory) begin
            state_q <= DONE;
          end else if (hit_full) begin
            inc_q   <= 1'b1;
            wait_q  <= '0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          wait_q <= wait_sum_d;
          if (victory) begin
            state_q <= DONE;
          end else if (newLevel) begin
            state_q <= PLAY;
          end else if (wait_timeout) begin
            level_err_q <= 1'b1;
            state_q     <= PLAY;
          end
        end
        default: ;
      endcase
    end
  end

  sym_tick_gen u_tick (
    .clk_i  (Clk100M),
    .rst_i  (Rst),
    .en_i   (tick_en),
    .clr_i  (tick_clr),
    .limit_i(symGenMax),
    .tick_o (symTick)
  );

  assign incLevel  = inc_q;
  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
  assign gameOver  = game_over_q;
  assign levelErr  = level_err_q;

`ifdef LEVEL_PROG_STATS_EN
  logic [15:0] total_hits_q;
  logic [3:0]  last_wait_q;
  logic        wait_exit;

  assign wait_exit = in_wait && (victory || newLevel || wait_timeout);

  always_ff @(posedge Clk100M) begin
    if (Rst) begin
      total_hits_q <= '0;
      last_wait_q  <= '0;
    end else begin
      if (counts_live && hit && (total_hits_q != 16'hFFFF)) total_hits_q <= total_hits_q + 16'd1;
      if (wait_exit) last_wait_q <= (wait_sum_d > WAIT_CNT_W'(15)) ? 4'hF : wait_sum_d[3:0];
    end
  end

  assign totalHits      = total_hits_q;
  assign lastWaitCycles = last_wait_q;
`endif

endmodule

// File: doc/level_progress_ctrl.md
Name: level_progress_ctrl

Overview:
Game-side producer for the level controller's `incLevel` / `newLevel` / `victory` / `symGenMax` interface.
- Counts player hits and misses.
- Issues single-cycle level-advance requests and waits for the level controller's acknowledgement.
- Produces the symbol-generation tick, whose period is `symGenMax` clock cycles.
- Sits between the symbol-match logic and the level controller.

Parameters:
- `HITS_PER_LEVEL`, default 10: hits required to request the next level (≥1).
- `MAX_MISSES`, default 3: misses that end the game (≥1).
- `WAIT_TIMEOUT`, default 8: cycles to wait for `newLevel`/`victory` before flagging an error.

Ports:
- `Clk100M` in 1: 100 MHz clock; sole clock.
- `Rst` in 1: reset, synchronous, active-high.
- `hit` in 1: one-cycle pulse, correct symbol entered.
- `miss` in 1: one-cycle pulse, wrong symbol or timeout.
- `newLevel` in 1: ack pulse from level controller; `symGenMax` is updated on the same edge.
- `victory` in 1: level controller reached final level (level-sensitive, sticky upstream).
- `symGenMax` in 32: current symbol period in cycles.
- `incLevel` out 1: registered one-cycle level-advance request.
- `symTick` out 1: registered one-cycle pulse, "generate next symbol".
- `hitCount` out 8: hits in current level.
- `missCount` out 4: misses this game.
- `gameOver` out 1: sticky, misses exhausted.
- `levelErr` out 1: sticky, advance request not acknowledged.

Behaviour:
- Single clock; reset is synchronous and active-high. `Rst` sampled on `Clk100M` rising edge overrides everything and aborts any pending request.
- Reset values: state=PLAY, all outputs 0, tick counter 0, wait counter 0.
- `incLevel` must never be high for more than 1 cycle; the level controller advances once per high cycle.

State machine:
- PLAY
  - Tick counter counts 0..max(`symGenMax`,1)-1. `symTick`=1 in the cycle after the counter equals the limit; the counter then returns to 0.
  - `symGenMax`=0 or 1 → `symTick` every cycle.
  - `hit` → `hitCount`+1.
  - If `hitCount`+1 == `HITS_PER_LEVEL`:
    - `incLevel`=1 next cycle.
    - `hitCount` cleared to 0.
    - Tick counter frozen; go to WAIT.
  - `miss` → `missCount`+1. If it reaches `MAX_MISSES`: `gameOver`=1, go LOST.
- WAIT
  - `symTick` held 0; `hit`/`miss` ignored; wait counter increments.
  - `newLevel` → tick counter cleared to 0 (new `symGenMax` applies from the first PLAY cycle), go PLAY.
  - `victory` → go DONE.
  - Wait counter reaches `WAIT_TIMEOUT` → `levelErr`=1, go PLAY with no resend.
- DONE: terminal until `Rst`; `symTick`/`incLevel` 0; counters frozen.
- LOST: terminal until `Rst`; same as DONE.

Priority and corner cases:
- Priority: `Rst` > LOST transition > `victory` > advance.
- `hit` and `miss` in the same PLAY cycle:
  - Both counters update.
  - If the miss exhausts `MAX_MISSES`, go LOST and suppress `incLevel`.
- `victory` high in PLAY → DONE; `hitCount` frozen.
- `victory` in WAIT at the same time as `newLevel` → DONE.
- Saturation: `missCount` saturates at `MAX_MISSES`; `hitCount` never exceeds `HITS_PER_LEVEL`-1.
- Latency, qualifying `hit` → `incLevel`: 1 cycle.
- Latency, `incLevel` → earliest acknowledged PLAY: 2 cycles (controller registers `newLevel`).

Optional Feature:
- Macro: `LEVEL_PROG_STATS_EN`.
- Defined:
  - Adds output `totalHits` (16 bits), saturating at 0xFFFF.
  - Counts every accepted hit across levels; cleared only by `Rst`.
  - Adds output `lastWaitCycles` (4 bits): cycles spent in the most recent WAIT.
- Undefined: both ports and their logic absent; all other behaviour identical.

Decomposition:
- Shared package `sym_game_pkg` holds:
  - State enum: PLAY, WAIT, DONE, LOST.
  - `SYM_PERIOD_W`=32.
  - Defaults for `HITS_PER_LEVEL`, `MAX_MISSES`, `WAIT_TIMEOUT`.
- One sub-module, `sym_tick_gen`:
  - Programmable period counter with enable/clear inputs and limit input; produces `symTick`.
  - Owns the `symGenMax` 0/1 clamp.

Test Plan:
- Reset then `symGenMax`=5, no hits → `symTick` pulses every 5 cycles. Assert `Rst` mid-count → next pulse exactly 5 cycles after deassert.
- 10 `hit` pulses with `HITS_PER_LEVEL`=10 → exactly one `incLevel` cycle, 1 cycle after the 10th hit; `hitCount`=0. Respond with `newLevel` 1 cycle later and `symGenMax`=3 → ticks resume every 3 cycles.
- In WAIT: send 4 `hit` + 3 `miss` → counters unchanged, no `gameOver`, `symTick`=0 throughout.
- Withhold `newLevel` → `levelErr`=1 after 8 WAIT cycles; returns to PLAY; no second `incLevel`.
- 3 `miss` pulses; on the 3rd also pulse `hit` making `hitCount` reach 10 → `gameOver`=1, `incLevel` never asserted, state LOST.
- `victory` asserted during WAIT → DONE. Further `hit`/`newLevel` → no outputs change until `Rst`.
